// File: rtl/alu_operand_loader.sv
// Front end of the N-bit ALU. It synchronises and debounces the pushbuttons and
// sequences operand entry (A, then B, then op) into registered ALU inputs.
module alu_operand_loader #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [2:0]   op_sw,
    input  logic         btn_load_n,
    input  logic         btn_clear_n,
    input  logic         btn_sum_n,
    input  logic         btn_subt_n,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [2:0]   op,
    output logic         op_sum,
    output logic         op_subt,
    output logic         operands_valid,
    output logic [1:0]   state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam int BTN_LOAD  = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_SUM   = 2;
    localparam int BTN_SUBT  = 3;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        READY   = 2'd3
    } state_t;

    logic [3:0] btn_raw_n;
    logic [3:0] deb_lvl;
    logic [3:0] deb_prev_reg;

    assign btn_raw_n = {btn_subt_n, btn_sum_n, btn_clear_n, btn_load_n};

    // Per button: 2-FF synchroniser followed by a saturating agreement counter.
    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          lvl_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    lvl_reg   <= 1'b1;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw_n[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == lvl_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        lvl_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_lvl[gi] = lvl_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_prev_reg <= '1;
        end else begin
            deb_prev_reg <= deb_lvl;
        end
    end

    logic load_evt;
    logic clear_evt;

    // One-cycle pulse on the debounced press edge only; release is ignored.
    assign load_evt  = deb_prev_reg[BTN_LOAD]  & ~deb_lvl[BTN_LOAD];
    assign clear_evt = deb_prev_reg[BTN_CLEAR] & ~deb_lvl[BTN_CLEAR];

    state_t       state_reg, state_next;
    logic [N-1:0] a_reg, a_next;
    logic [N-1:0] b_reg, b_next;
    logic [2:0]   op_reg, op_next;
    logic         valid_reg;
    logic         op_sum_reg;
    logic         op_subt_reg;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        if (clear_evt) begin
            state_next = LOAD_A;
            a_next     = '0;
            b_next     = '0;
            op_next    = 3'b111;
        end else if (load_evt) begin
            case (state_reg)
                LOAD_A: begin
                    a_next     = sw;
                    state_next = LOAD_B;
                end
                LOAD_B: begin
                    b_next     = sw;
                    state_next = LOAD_OP;
                end
                LOAD_OP: begin
                    op_next    = op_sw;
                    state_next = READY;
                end
                READY: begin
                    a_next     = sw;
                    state_next = LOAD_B;
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= LOAD_A;
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= 3'b111;
            valid_reg   <= 1'b0;
            op_sum_reg  <= 1'b0;
            op_subt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            op_reg      <= op_next;
            valid_reg   <= (state_next == READY);
            op_sum_reg  <= ~deb_lvl[BTN_SUM];
            // Sum has priority when both buttons are held.
            op_subt_reg <= ~deb_lvl[BTN_SUBT] & deb_lvl[BTN_SUM];
        end
    end

    assign a              = a_reg;
    assign b              = b_reg;
    assign op             = op_reg;
    assign op_sum         = op_sum_reg;
    assign op_subt        = op_subt_reg;
    assign operands_valid = valid_reg;
    assign state          = state_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: table-driven load sequence with a
// scoreboard queue, plus hand-written bounce, clear, sum/subt and reset cases.
module tb_alu_operand_loader;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sw = '0;
    logic [2:0]   op_sw = 3'b000;
    logic         btn_load_n = 1'b1;
    logic         btn_clear_n = 1'b1;
    logic         btn_sum_n = 1'b1;
    logic         btn_subt_n = 1'b1;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         op_sum;
    logic         op_subt;
    logic         operands_valid;
    logic [1:0]   state;

    alu_operand_loader #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .sw             (sw),
        .op_sw          (op_sw),
        .btn_load_n     (btn_load_n),
        .btn_clear_n    (btn_clear_n),
        .btn_sum_n      (btn_sum_n),
        .btn_subt_n     (btn_subt_n),
        .a              (a),
        .b              (b),
        .op             (op),
        .op_sum         (op_sum),
        .op_subt        (op_subt),
        .operands_valid (operands_valid),
        .state          (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [N-1:0] sw;
        logic [2:0]   op_sw;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [1:0]   st;
    } vec_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
        logic [1:0]   st;
    } exp_t;

    vec_t vecs[6];
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    task automatic push_exp(input logic [N-1:0] ea, input logic [N-1:0] eb,
                            input logic [2:0] eop, input logic [1:0] est);
        exp_t e;
        e.a = ea; e.b = eb; e.op = eop; e.st = est;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        $display("%s: a=%0d b=%0d op=%0d state=%0d valid=%0d (exp a=%0d b=%0d op=%0d state=%0d)",
                 tag, a, b, op, state, operands_valid, e.a, e.b, e.op, e.st);
        check({tag, "_a"}, int'(a), int'(e.a));
        check({tag, "_b"}, int'(b), int'(e.b));
        check({tag, "_op"}, int'(op), int'(e.op));
        check({tag, "_state"}, int'(state), int'(e.st));
        check({tag, "_valid"}, int'(operands_valid), (e.st == 2'd3) ? 1 : 0);
    endtask

    // Called at a negedge: press load for `hold` sampled edges, watch 30 edges,
    // and report the edge count at which the FSM state first changed.
    task automatic press_load(input int hold, output int lat);
        logic [1:0] snap;
        snap = state;
        lat = -1;
        btn_load_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (lat < 0 && state != snap) lat = k;
            if (k == hold) btn_load_n = 1'b1;
        end
    endtask

    initial begin
        int lat;
        int saw_ready;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("reset: a=%0d b=%0d op=%0d state=%0d", a, b, op, state);
        check("reset_a", int'(a), 0);
        check("reset_b", int'(b), 0);
        check("reset_op", int'(op), 7);
        check("reset_op_sum", int'(op_sum), 0);
        check("reset_op_subt", int'(op_subt), 0);
        check("reset_valid", int'(operands_valid), 0);
        check("reset_state", int'(state), 0);

        vecs[0] = '{sw: 4'h9, op_sw: 3'd0, a: 4'h9, b: 4'h0, op: 3'd7, st: 2'd1};
        vecs[1] = '{sw: 4'h3, op_sw: 3'd0, a: 4'h9, b: 4'h3, op: 3'd7, st: 2'd2};
        vecs[2] = '{sw: 4'h0, op_sw: 3'd5, a: 4'h9, b: 4'h3, op: 3'd5, st: 2'd3};
        vecs[3] = '{sw: 4'h6, op_sw: 3'd1, a: 4'h6, b: 4'h3, op: 3'd5, st: 2'd1};
        vecs[4] = '{sw: 4'hC, op_sw: 3'd1, a: 4'h6, b: 4'hC, op: 3'd5, st: 2'd2};
        vecs[5] = '{sw: 4'h1, op_sw: 3'd2, a: 4'h6, b: 4'hC, op: 3'd2, st: 2'd3};

        for (int i = 0; i < 6; i++) begin
            sw = vecs[i].sw;
            op_sw = vecs[i].op_sw;
            push_exp(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].st);
            press_load(10, lat);
            check($sformatf("vec%0d_latency", i), lat, 7);
            sw = ~sw;
            op_sw = ~op_sw;
            repeat (2) @(negedge clk);
            pop_compare($sformatf("vec%0d", i));
        end

        // Walk to LOAD_OP, then press load and clear together.
        sw = 4'h1;
        push_exp(4'h1, 4'hC, 3'd2, 2'd1);
        press_load(10, lat);
        pop_compare("clr_setup_a");
        sw = 4'h2;
        push_exp(4'h1, 4'h2, 3'd2, 2'd2);
        press_load(10, lat);
        pop_compare("clr_setup_b");
        op_sw = 3'b000;
        saw_ready = 0;
        btn_load_n = 1'b0;
        btn_clear_n = 1'b0;
        push_exp(4'h0, 4'h0, 3'd7, 2'd0);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (operands_valid) saw_ready = 1;
            if (k == 10) begin
                btn_load_n = 1'b1;
                btn_clear_n = 1'b1;
            end
        end
        check("clear_no_capture", saw_ready, 0);
        pop_compare("clear_priority");

        // Bounce: 3 low, 1 high, 2 low, then released.
        btn_load_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_load_n = 1'b1;
        @(negedge clk);
        btn_load_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_load_n = 1'b1;
        repeat (15) @(negedge clk);
        $display("bounce: state=%0d a=%0d", state, a);
        check("bounce_state", int'(state), 0);
        check("bounce_a", int'(a), 0);
        sw = 4'h5;
        push_exp(4'h5, 4'h0, 3'd7, 2'd1);
        press_load(6, lat);
        check("bounce_press6_latency", lat, 7);
        pop_compare("bounce_press6");

        // Sum / subtract levels.
        btn_sum_n = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && op_sum) lat = k;
        end
        $display("sum press: op_sum=%0d latency=%0d", op_sum, lat);
        check("sum_latency", lat, 7);
        btn_subt_n = 1'b0;
        repeat (12) @(negedge clk);
        $display("sum+subt held: op_sum=%0d op_subt=%0d", op_sum, op_subt);
        check("both_op_sum", int'(op_sum), 1);
        check("both_op_subt", int'(op_subt), 0);
        btn_sum_n = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && op_subt) lat = k;
        end
        $display("subt only: op_sum=%0d op_subt=%0d latency=%0d", op_sum, op_subt, lat);
        check("subt_latency", lat, 7);
        check("subt_op_sum", int'(op_sum), 0);
        check("sumsubt_state_untouched", int'(state), 1);
        btn_subt_n = 1'b1;
        repeat (12) @(negedge clk);
        check("subt_release", int'(op_subt), 0);

        // Reset while a press is mid-debounce.
        sw = 4'hA;
        btn_load_n = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_state", int'(state), 0);
        check("midrst_a", int'(a), 0);
        lat = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (lat < 0 && state != 2'd0) lat = k;
            if (k == 10) btn_load_n = 1'b1;
        end
        $display("reset mid-debounce: state=%0d a=%0d latency=%0d", state, a, lat);
        check("midrst_latency", lat, 7);
        check("midrst_capture_a", int'(a), 10);
        check("midrst_capture_state", int'(state), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream front end of the N-bit ALU.
- Turns board switches and active-low pushbuttons (low = pressed) into stable, registered ALU operands a, b, op and the op_sum/op_subt controls.
- Synchronises and debounces every button, then sequences operand entry with a small FSM: A, then B, then op.
- Outputs feed the ALU's a, b, op, op_sum and op_subt inputs directly.

Parameters:
- N, 4, operand width; must match the downstream ALU.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required before a debounced level changes; range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sw  input  N  operand switches, sampled on capture
- op_sw  input  3  operation-select switches, sampled on capture
- btn_load_n  input  1  load button, active-low (low = pressed)
- btn_clear_n  input  1  clear button, active-low
- btn_sum_n  input  1  sum button, active-low
- btn_subt_n  input  1  subtract button, active-low
- a  output  N  registered operand A
- b  output  N  registered operand B
- op  output  3  registered operation select
- op_sum  output  1  debounced sum request, active-high level
- op_subt  output  1  debounced subtract request, active-high level
- operands_valid  output  1  high while in READY
- state  output  2  current FSM state: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3

Behaviour:
- Reset, on any rising clk with rst=1:
  - a=0, b=0, op=3'b111, op_sum=0, op_subt=0, operands_valid=0, state=LOAD_A.
  - Synchroniser flops preset to 1 (released); debounce counters=0; debounced levels=1 (released).
  - rst overrides everything, including a capture or debounce in progress.
- Button conditioning, per button, identical:
  - 2-FF synchroniser.
  - Counter increments while the synchronised sample differs from the debounced level; any equal sample resets it to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Latency: a raw level held stable flips the debounced level exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are never seen downstream.
- Press events:
  - load_evt and clear_evt are one-cycle internal pulses on a debounced 1->0 transition.
  - Holding a button produces exactly one event. Release produces none.
- FSM transitions (registered, on the edge after the event cycle):
  - LOAD_A + load_evt: a<=sw, go to LOAD_B.
  - LOAD_B + load_evt: b<=sw, go to LOAD_OP.
  - LOAD_OP + load_evt: op<=op_sw, go to READY.
  - READY + load_evt: a<=sw, go to LOAD_B (start a new entry; b and op hold their old values until overwritten).
  - clear_evt in any state: a=0, b=0, op=3'b111, go to LOAD_A.
  - Simultaneous clear_evt and load_evt: clear wins and no capture occurs.
- Output validity:
  - operands_valid = (state==READY), registered with state.
  - a, b and op change only on capture, clear or reset. They never glitch between captures.
  - Switch inputs are sampled only on the capture edge; switch changes at other times have no effect.
- op_sum / op_subt:
  - Registered copies of the inverted debounced btn_sum_n / btn_subt_n levels, updated one edge after the debounced change.
  - Independent of FSM state.
  - Both buttons held: op_sum=1, op_subt=0 (sum has priority).
  - Holding only btn_subt_n gives op_subt=1.
- Width rules: no arithmetic on operands. Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).

Test Plan:
- Reset: rst=1 for 2 edges with all buttons released -> a=0, b=0, op=3'b111, op_sum=0, op_subt=0, operands_valid=0, state=0.
- Full load sequence with DEBOUNCE_CYCLES=4:
  - Stimulus: press btn_load_n three times, each held 10 cycles, with sw=4'b1001, then sw=4'b0011, then op_sw=3'b101.
  - Required: a=9, b=3, op=5, state=3, operands_valid=1.
  - Each capture lands exactly 2+4+1 edges after the press begins.
- Bounce rejection: btn_load_n low for 3 cycles, high 1, low 2, high -> no capture, state stays 0. A subsequent 6-cycle press -> exactly one capture.
- Clear priority: in LOAD_OP, assert btn_load_n and btn_clear_n low on the same edge and hold 10 cycles -> state=0, a=0, b=0, op=3'b111, no capture of op_sw.
- Sum/subtract: hold btn_sum_n low -> op_sum=1 after 7 edges. Add btn_subt_n low -> op_sum=1, op_subt=0. Release btn_sum_n -> op_subt=1 after 7 edges.
- Reset mid-debounce: btn_load_n low for 4 cycles, pulse rst, keep the button low -> no stale capture. The press is re-debounced from zero and captures a<=sw 7 edges after rst deasserts.
